eval_iter: RTL and testbench

Parametrised, multi-cycle Wordle-style guess evaluator: takes a guess and a solution of `LEN` letters of `LW` bits each and produces a 2-bit colour per letter (grey/yellow/green), with duplicate-letter handling. It sits between the guess-entry path and the display/scoring logic. It replaces the single-cycle fixed 5×5 evaluator with one comparison position per cycle and a valid/ready handshake on both sides, so word length and alphabet width can grow without a wide combinational cone.

---
 rtl/eval_iter_if.sv | 27 ++
 rtl/eval_iter.sv | 128 ++++++++++++
 tb/tb_eval_iter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/eval_iter_if.sv
// Handshake bundle for the iterative guess evaluator: job input side
// (guess/solution) and result output side (colors/win).
interface eval_iter_if #(
  parameter int LEN = 5,
  parameter int LW  = 5
) ();
  logic                in_valid;
  logic                in_ready;
  logic [LEN*LW-1:0]   guess;
  logic [LEN*LW-1:0]   solution;
  logic                out_valid;
  logic                out_ready;
  logic [2*LEN-1:0]    colors;
  logic                win;

  // Job producer / result consumer side.
  modport master (
    output in_valid, guess, solution, out_ready,
    input  in_ready, out_valid, colors, win
  );

  // Evaluator side.
  modport slave (
    input  in_valid, guess, solution, out_ready,
    output in_ready, out_valid, colors, win
  );
endinterface

// File: rtl/eval_iter.sv
// Multi-cycle Wordle-style evaluator. One GREEN cycle compares all
// positions in parallel, then SCAN resolves the yellow/grey decision for
// one position per cycle so the comparison cone grows only linearly with LEN.
module eval_iter #(
  parameter int LEN = 5,
  parameter int LW  = 5
) (
  input  logic        clk,
  input  logic        rst,
  eval_iter_if.slave  bus
);

  localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int CW = $clog2(LEN + 1);

  typedef enum logic [1:0] {IDLE, GREEN, SCAN, DONE} state_t;

  state_t             state_q, state_d;
  logic [LW-1:0]      g_q [LEN];
  logic [LW-1:0]      s_q [LEN];
  logic [LEN-1:0]     green_q, green_d;
  logic [LEN-1:0]     yellow_q, yellow_d;
  logic [IW-1:0]      idx_q;
  logic [CW-1:0]      cnt_sol, cnt_g;
  logic               yellow_bit;
  logic               last_pos;
  logic               accept;
  logic [2*LEN-1:0]   colors_q, colors_d;
  logic               win_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign last_pos = (idx_q == IW'(LEN - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: accept -> GREEN -> LEN x SCAN -> DONE -> handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = GREEN;
      GREEN:   state_d = SCAN;
      SCAN:    if (last_pos) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs; in_ready is held low while reset is asserted.
  always_comb begin
    bus.in_ready  = (state_q == IDLE) && !rst;
    bus.out_valid = (state_q == DONE);
  end

  // Job capture; letters are only read after a valid accept.
  // NOTE: data-only registers need no reset -- they are always written by
  // the accept before any state that reads them, so reset logic would be waste.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < LEN; k++) begin
        g_q[k] <= bus.guess[LW*k +: LW];
        s_q[k] <= bus.solution[LW*k +: LW];
      end
    end
  end

  // Per-position comparison: parallel greens and the yellow test for idx.
  // NOTE: combinational blocks use blocking '=' so the running counts
  // accumulate within one evaluation; clocked blocks use '<=' only.
  always_comb begin
    green_d = '0;
    for (int k = 0; k < LEN; k++) green_d[k] = (g_q[k] == s_q[k]);

    cnt_sol = '0;
    cnt_g   = CW'(1);
    for (int j = 0; j < LEN; j++) begin
      if (j != int'(idx_q) && !green_q[j] && g_q[idx_q] == s_q[j])
        cnt_sol = cnt_sol + CW'(1);
      if (j < int'(idx_q) && !green_q[j] && g_q[idx_q] == g_q[j])
        cnt_g = cnt_g + CW'(1);
    end
    yellow_bit = !green_q[idx_q] && (cnt_sol >= cnt_g);

    yellow_d        = yellow_q;
    yellow_d[idx_q] = yellow_bit;

    colors_d = '0;
    for (int k = 0; k < LEN; k++)
      colors_d[2*k +: 2] = {green_q[k] | yellow_d[k], green_q[k] | !yellow_d[k]};
  end

  // Evaluation state and registered result; result updates on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      green_q  <= '0;
      yellow_q <= '0;
      idx_q    <= '0;
      colors_q <= '0;
      win_q    <= 1'b0;
    end else begin
      case (state_q)
        GREEN: begin
          green_q  <= green_d;
          yellow_q <= '0;
          idx_q    <= '0;
        end
        SCAN: begin
          yellow_q <= yellow_d;
          if (last_pos) begin
            idx_q    <= '0;
            colors_q <= colors_d;
            win_q    <= &green_q;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.colors = colors_q;
  assign bus.win    = win_q;

endmodule

// File: tb/tb_eval_iter.sv
// Directed bench for eval_iter: a LEN=5/LW=5 instance for the main
// scenarios and a LEN=6/LW=8 instance for parametrisation. Expected results
// come from a letter-count reference model and sit in a queue per instance.
module tb_eval_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  logic [32:0] exp_a [$];
  logic [32:0] exp_b [$];

  eval_iter_if #(.LEN(5), .LW(5)) a ();
  eval_iter_if #(.LEN(6), .LW(8)) b ();

  eval_iter #(.LEN(5), .LW(5)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
  eval_iter #(.LEN(6), .LW(8)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Word to packed letters, letter 0 = first character, A=0.
  function automatic logic [127:0] wd(input string w, input int lw);
    logic [127:0] r;
    logic [7:0]   c;
    r = '0;
    for (int i = 0; i < w.len(); i++) begin
      c = w[i];
      r = r | (128'(c - 8'd65) << (lw * i));
    end
    return r;
  endfunction

  // Reference: remove greens, count leftover solution letters, then hand
  // out yellows left to right while the count for that letter lasts.
  function automatic logic [32:0] model(input int len, input int lw,
                                        input logic [127:0] g, input logic [127:0] s);
    int          left [256];
    logic [31:0] col;
    logic        win;
    logic [15:0] gr;
    logic [7:0]  gl, sl, mask;
    col  = '0;
    win  = 1'b1;
    gr   = '0;
    mask = 8'((1 << lw) - 1);
    foreach (left[c]) left[c] = 0;
    for (int k = 0; k < len; k++) begin
      gl    = g[lw*k +: 8] & mask;
      sl    = s[lw*k +: 8] & mask;
      gr[k] = (gl == sl);
      if (!gr[k]) begin
        left[sl]++;
        win = 1'b0;
      end
    end
    for (int k = 0; k < len; k++) begin
      gl = g[lw*k +: 8] & mask;
      if (gr[k]) col[2*k +: 2] = 2'b11;
      else if (left[gl] > 0) begin
        col[2*k +: 2] = 2'b10;
        left[gl]--;
      end else col[2*k +: 2] = 2'b01;
    end
    return {win, col};
  endfunction

  // Present a job to instance A (called at a negedge, returns at the
  // negedge following the accept edge with that cycle count).
  task automatic send_a(input logic [127:0] g, input logic [127:0] s, output int acc_cyc);
    bit got;
    got = 1'b0;
    a.in_valid = 1'b1;
    a.guess    = g[24:0];
    a.solution = s[24:0];
    for (int n = 0; n < 50; n++) begin
      if (a.in_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("accept_a", 64'(got), 64'd1);
    if (got) begin
      exp_a.push_back(model(5, 5, g, s));
      @(negedge clk);
    end
    acc_cyc    = cyc;
    a.in_valid = 1'b0;
  endtask

  // Wait for A's result, compare against the scoreboard head.
  task automatic recv_a(input string tag, input int acc_cyc, input int lat,
                        output logic [32:0] e);
    bit got;
    got = 1'b0;
    e   = '0;
    for (int n = 0; n < 40; n++) begin
      if (a.out_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_valid"}, 64'(got), 64'd1);
    if (got) begin
      if (lat > 0) check({tag, "_latency"}, 64'(cyc - acc_cyc), 64'(lat));
      check({tag, "_sb_nonempty"}, 64'(exp_a.size() > 0), 64'd1);
      if (exp_a.size() > 0) begin
        e = exp_a.pop_front();
        check({tag, "_colors"}, 64'(a.colors), 64'(e[9:0]));
        check({tag, "_win"}, 64'(a.win), 64'(e[32]));
      end
    end
  endtask

  initial begin
    int           acc;
    logic [32:0]  e;
    logic [127:0] g, s;
    bit           got;

    a.in_valid = 1'b0; a.out_ready = 1'b1; a.guess = '0; a.solution = '0;
    b.in_valid = 1'b0; b.out_ready = 1'b1; b.guess = '0; b.solution = '0;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(a.in_ready), 64'd0);
    check("rst_out_valid", 64'(a.out_valid), 64'd0);
    check("rst_colors", 64'(a.colors), 64'd0);
    check("rst_win", 64'(a.win), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(a.in_ready), 64'd1);

    // Exact match, consumer ready: latency LEN+1, single-cycle out_valid.
    send_a(wd("CRANE", 5), wd("CRANE", 5), acc);
    recv_a("crane", acc, 6, e);
    check("crane_const", 64'(a.colors), 64'h3FF);
    @(negedge clk);
    check("crane_valid_drop", 64'(a.out_valid), 64'd0);
    check("crane_ready_back", 64'(a.in_ready), 64'd1);

    // Duplicate-letter cases.
    send_a(wd("SPEED", 5), wd("ABIDE", 5), acc);
    recv_a("speed", acc, 6, e);
    check("speed_const", 64'(a.colors), 64'h265);
    @(negedge clk);
    send_a(wd("EERIE", 5), wd("THREE", 5), acc);
    recv_a("eerie", acc, 6, e);
    check("eerie_const", 64'(a.colors), 64'h376);
    @(negedge clk);

    // Backpressure: result held, no accept while in_valid toggles guesses.
    a.out_ready = 1'b0;
    send_a(wd("HELLO", 5), wd("WORLD", 5), acc);
    recv_a("stall", acc, 6, e);
    for (int n = 0; n < 10; n++) begin
      a.in_valid = 1'b1;
      a.guess    = 25'($urandom);
      @(negedge clk);
      check("stall_valid", 64'(a.out_valid), 64'd1);
      check("stall_colors", 64'(a.colors), 64'(e[9:0]));
      check("stall_win", 64'(a.win), 64'(e[32]));
      check("stall_in_ready", 64'(a.in_ready), 64'd0);
    end
    a.in_valid  = 1'b0;
    a.out_ready = 1'b1;
    @(negedge clk);
    check("stall_release_valid", 64'(a.out_valid), 64'd0);
    check("stall_release_ready", 64'(a.in_ready), 64'd1);
    repeat (3) @(negedge clk);
    check("stall_no_second", 64'(a.out_valid), 64'd0);

    // Reset mid-SCAN: job discarded, outputs return to reset values.
    send_a(wd("CRANE", 5), wd("SLATE", 5), acc);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midscan_rst_valid", 64'(a.out_valid), 64'd0);
    check("midscan_rst_colors", 64'(a.colors), 64'd0);
    check("midscan_rst_win", 64'(a.win), 64'd0);
    check("midscan_rst_ready", 64'(a.in_ready), 64'd0);
    void'(exp_a.pop_back());
    rst = 1'b0;
    #1;
    check("midscan_release_ready", 64'(a.in_ready), 64'd1);
    @(negedge clk);
    send_a(wd("CRANE", 5), wd("NACRE", 5), acc);
    recv_a("nacre", acc, 6, e);
    @(negedge clk);

    // Reset while DONE is stalled.
    a.out_ready = 1'b0;
    send_a(wd("QUEUE", 5), wd("UVULA", 5), acc);
    recv_a("done_rst", acc, 6, e);
    rst = 1'b1;
    @(negedge clk);
    check("done_rst_valid", 64'(a.out_valid), 64'd0);
    check("done_rst_colors", 64'(a.colors), 64'd0);
    rst = 1'b0;
    a.out_ready = 1'b1;
    @(negedge clk);

    // Small alphabet random jobs to stress duplicate handling.
    for (int t = 0; t < 8; t++) begin
      g = '0;
      s = '0;
      for (int k = 0; k < 5; k++) begin
        g[5*k +: 5] = 5'($urandom_range(0, 3));
        s[5*k +: 5] = 5'($urandom_range(0, 3));
      end
      send_a(g, s, acc);
      recv_a("rand_a", acc, 6, e);
      @(negedge clk);
    end

    // LEN=6, LW=8 instance.
    for (int t = 0; t < 3; t++) begin
      if (t == 0) begin
        g = wd("AABBCC", 8);
        s = wd("ABCABC", 8);
      end else begin
        g = '0;
        s = '0;
        for (int k = 0; k < 6; k++) begin
          g[8*k +: 8] = 8'($urandom_range(0, 2));
          s[8*k +: 8] = 8'($urandom_range(0, 2));
        end
      end
      check("b_in_ready", 64'(b.in_ready), 64'd1);
      b.in_valid = 1'b1;
      b.guess    = g[47:0];
      b.solution = s[47:0];
      exp_b.push_back(model(6, 8, g, s));
      @(negedge clk);
      acc = cyc;
      b.in_valid = 1'b0;
      got = 1'b0;
      for (int n = 0; n < 40; n++) begin
        if (b.out_valid) begin
          got = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check("b_valid", 64'(got), 64'd1);
      if (got) begin
        e = exp_b.pop_front();
        check("b_latency", 64'(cyc - acc), 64'd7);
        check("b_colors", 64'(b.colors), 64'(e[11:0]));
        check("b_win", 64'(b.win), 64'(e[32]));
      end
      @(negedge clk);
      check("b_valid_drop", 64'(b.out_valid), 64'd0);
    end

    check("sb_a_drained", 64'(exp_a.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
